// File: rtl/fb_row_fetch.sv
// fb_row_fetch: walks one framebuffer row through the RAM read port and
// streams RGB565 pixels with column tags over a valid/ready handshake.
// Optional build macro: FB_ROW_FETCH_BYTESWAP_EN swaps the two bytes of
// each RAM word as it enters the skid FIFO.
//
// Handshake: pix_valid/pix_data/pix_col/pix_last come from the FIFO head.
// A pixel transfers on a rising edge where pix_valid & pix_ready are both
// high. Once pix_valid rises it stays high, with the payload unchanged,
// until that transfer happens.
module fb_row_fetch #(
    parameter int COL_BITS   = 6,
    parameter int ROW_BITS   = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         row_req,
    input  logic [ROW_BITS-1:0]          row_sel,
    output logic [COL_BITS+ROW_BITS-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0]        ram_data,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [DATA_WIDTH-1:0]        pix_data,
    output logic [COL_BITS-1:0]          pix_col,
    output logic                         pix_last,
    output logic                         busy,
    output logic                         row_done,
    output logic [1:0]                   dbg_state
);
    localparam int AW = COL_BITS + ROW_BITS;
    localparam logic [COL_BITS-1:0] COL_MAX = '1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [AW-1:0]         ram_addr_q, ram_addr_d;
    logic                  inflight_q, inflight_d;
    logic [COL_BITS-1:0]   tag_q, tag_d;
    logic                  busy_q, busy_d;
    logic                  row_done_q, row_done_d;

    // Two-entry skid FIFO storage and pointers.
    logic [DATA_WIDTH-1:0] mem_data_q [2];
    logic [DATA_WIDTH-1:0] mem_data_d [2];
    logic [COL_BITS-1:0]   mem_col_q  [2];
    logic [COL_BITS-1:0]   mem_col_d  [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  push, pop, can_issue;
    logic [2:0]            occ_after_pop;
    logic [COL_BITS-1:0]   cur_col;
    logic [DATA_WIDTH-1:0] wr_data;

    assign cur_col   = ram_addr_q[COL_BITS-1:0];
    assign pix_valid = (count_q != 2'd0);
    assign pix_data  = mem_data_q[rd_ptr_q];
    assign pix_col   = mem_col_q[rd_ptr_q];
    assign pix_last  = pix_valid && (pix_col == COL_MAX);
    assign pop       = pix_valid && pix_ready;
    // The word read for the address issued last cycle is on ram_data now.
    assign push      = inflight_q;

`ifdef FB_ROW_FETCH_BYTESWAP_EN
    assign wr_data = {ram_data[7:0], ram_data[15:8]};
`else
    assign wr_data = ram_data;
`endif

    // Issue only if the FIFO can still hold everything already requested,
    // counting the slot freed by a pop in this same cycle.
    assign occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign can_issue     = (occ_after_pop < 3'd2);

    assign ram_addr  = ram_addr_q;
    assign busy      = busy_q;
    assign row_done  = row_done_q;
    assign dbg_state = state_q;

    // Control FSM: row capture, address walk, end-of-row detection.
    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        busy_d     = busy_q;
        row_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (row_req) begin
                    ram_addr_d = {row_sel, {COL_BITS{1'b0}}};
                    busy_d     = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // The RAM samples the presented address on this edge; mark it
                // as in flight only when there is room to land the result.
                if (can_issue) begin
                    inflight_d = 1'b1;
                    tag_d      = cur_col;
                    if (cur_col == COL_MAX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        ram_addr_d = ram_addr_q + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && pix_last) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    row_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO next state: push at tail, pop at head, order preserved.
    always_comb begin
        mem_data_d = mem_data_q;
        mem_col_d  = mem_col_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = wr_data;
            mem_col_d[wr_ptr_q]  = tag_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers; reset abandons any row in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ram_addr_q    <= '0;
            inflight_q    <= 1'b0;
            tag_q         <= '0;
            busy_q        <= 1'b0;
            row_done_q    <= 1'b0;
            mem_data_q[0] <= '0;
            mem_data_q[1] <= '0;
            mem_col_q[0]  <= '0;
            mem_col_q[1]  <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            row_done_q <= row_done_d;
            mem_data_q <= mem_data_d;
            mem_col_q  <= mem_col_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_fb_row_fetch.sv
// Bench for fb_row_fetch: registered RAM model, ready-pattern driver,
// scoreboard of expected pixels filled at each row request.
module tb_fb_row_fetch;
  localparam int CB = 6;
  localparam int RB = 5;
  localparam int DW = 16;
  localparam int AW = CB + RB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          row_req = 1'b0;
  logic [RB-1:0] row_sel = '0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic [DW-1:0] pix_data;
  logic [CB-1:0] pix_col;
  logic          pix_last;
  logic          busy;
  logic          row_done;
  logic [1:0]    dbg_state;

  fb_row_fetch #(.COL_BITS(CB), .ROW_BITS(RB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .row_req(row_req), .row_sel(row_sel),
    .ram_addr(ram_addr), .ram_data(ram_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_col(pix_col),
    .pix_last(pix_last), .busy(busy), .row_done(row_done), .dbg_state(dbg_state)
  );

  // ---------------- models ----------------
  function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
`ifdef FB_ROW_FETCH_BYTESWAP_EN
    return 16'h1234 + {5'd0, a};
`else
    return {5'd0, a};
`endif
  endfunction

  function automatic logic [DW-1:0] exp_pix(input logic [DW-1:0] w);
`ifdef FB_ROW_FETCH_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  // RAM with one-cycle registered read
  always @(posedge clk) ram_data <= model_word(ram_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [DW+CB:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int accepts = 0;
  int last_acc_cyc = -1;
  logic [RB-1:0] cur_row = '0;
  int rdy_mode = 0;
  int stall_left = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ~pix_ready;
        default: begin
          if (stall_left > 0) begin
            pix_ready = 1'b0;
            if (pix_valid) stall_left--;
          end else begin
            pix_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- output monitor ----------------
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [CB-1:0] prev_col = '0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", {31'd0, pix_valid}, 32'd1);
        check_eq("hold_data", {16'd0, pix_data}, {16'd0, prev_data});
        check_eq("hold_col", {26'd0, pix_col}, {26'd0, prev_col});
      end
      if (busy) begin
        check_eq("addr_row", {27'd0, ram_addr[AW-1:CB]}, {27'd0, cur_row});
        check_eq("addr_lead_le2", {31'd0, (int'(ram_addr[CB-1:0]) - accepts) <= 2}, 32'd1);
        if (pix_ready && accepts > 0 && accepts < 64)
          check_eq("no_bubble", {31'd0, pix_valid}, 32'd1);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pixel", {16'd0, pix_data}, 32'hFFFF_FFFF);
        end else begin
          logic [DW+CB:0] e;
          e = exp_q.pop_front();
          check_eq("pix_data", {16'd0, pix_data}, {16'd0, e[DW-1:0]});
          check_eq("pix_col", {26'd0, pix_col}, {26'd0, e[DW+CB-1:DW]});
          check_eq("pix_last", {31'd0, pix_last}, {31'd0, e[DW+CB]});
          accepts++;
          if (e[DW+CB]) last_acc_cyc = cyc + 1;
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_col   = pix_col;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_addr"}, {21'd0, ram_addr}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
    check_eq({tag, "_data"}, {16'd0, pix_data}, 32'd0);
    check_eq({tag, "_col"}, {26'd0, pix_col}, 32'd0);
    check_eq({tag, "_last"}, {31'd0, pix_last}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, row_done}, 32'd0);
    check_eq({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  task automatic request_row(input logic [RB-1:0] r);
    int n;
    @(posedge clk);
    #1;
    cur_row = r;
    accepts = 0;
    for (int c = 0; c < 64; c++) begin
      logic [AW-1:0] a;
      logic [CB-1:0] cc;
      cc = CB'(c);
      a = {r, cc};
      exp_q.push_back({(c == 63), cc, exp_pix(model_word(a))});
    end
    row_req = 1'b1;
    row_sel = r;
    @(posedge clk);
    #1;
    row_req = 1'b0;
    check_eq("busy_after_req", {31'd0, busy}, 32'd1);
    check_eq("addr_after_req", {21'd0, ram_addr}, {21'd0, r, 6'd0});
    n = 0;
    while (!pix_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("first_valid_latency", n, 32'd2);
  endtask

  task automatic wait_accepts(input int target);
    int n;
    n = 0;
    while (accepts < target && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("wait_accepts_timeout", {31'd0, accepts >= target}, 32'd1);
  endtask

  task automatic wait_row_done();
    int n;
    n = 0;
    while (!row_done && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("row_done_seen", {31'd0, row_done}, 32'd1);
    check_eq("busy_low_at_done", {31'd0, busy}, 32'd0);
    check_eq("accept_count", accepts, 32'd64);
    check_eq("queue_empty", exp_q.size(), 32'd0);
    check_eq("done_after_last", cyc, last_acc_cyc);
    check_eq("valid_low_at_done", {31'd0, pix_valid}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("row_done_pulse", {31'd0, row_done}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // full-rate row 3
    rdy_mode = 0;
    request_row(5'd3);
    wait_row_done();

    // ready toggling every cycle
    rdy_mode = 1;
    request_row(5'd3);
    wait_row_done();

    // long stall right after the first pixel appears
    stall_left = 10;
    rdy_mode = 2;
    request_row(5'd3);
    wait_row_done();

    // re-request mid-row is ignored; row 7 fetched afterwards
    rdy_mode = 0;
    request_row(5'd3);
    wait_accepts(20);
    @(posedge clk);
    #1;
    row_req = 1'b1;
    row_sel = 5'd7;
    @(posedge clk);
    #1;
    row_req = 1'b0;
    check_eq("busy_mid_row", {31'd0, busy}, 32'd1);
    wait_row_done();
    request_row(5'd7);
    wait_row_done();

    // reset mid-row, then fetch row 0
    request_row(5'd3);
    wait_accepts(20);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("valid_in_reset", {31'd0, pix_valid}, 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("valid_after_release", {31'd0, pix_valid}, 32'd0);
    request_row(5'd0);
    wait_row_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
